// File: rtl/dcache_2way_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_2way_pkg
// Description : Shared types and helpers for the 2-way write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_2way_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    localparam int c_OFFSET_W = 2;

    // Address bits consumed by an index field; zero when the field has one entry.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Storage width for an index field; never zero so vectors stay legal.
    function automatic int fieldWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tagWidth(input int addrW, input int sets, input int words);
        return addrW - c_OFFSET_W - idxWidth(sets) - idxWidth(words);
    endfunction

    function automatic logic [31:0] byteMerge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  be);
        logic [31:0] merged;
        merged = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = newWord[8*b +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_2way_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_2way_if
// Description : Pipeline-side request bus and memory-side beat bus of the cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_2way_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic [31:0]       rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    // master is the environment: pipeline requester plus main-memory responder
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, mem_ready, mem_rdata,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, mem_ready, mem_rdata,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dcache_way.sv
`default_nettype none
// ============================================================================
// Module      : dcache_way
// Description : One cache way: valid/dirty/tag/data storage, hit compare, word read.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_way #(
    parameter int SETS   = 64,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 22,
    parameter int SET_W  = 6,
    parameter int WORD_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [SET_W-1:0]  i_set,
    input  wire logic [TAG_W-1:0]  i_tag,
    input  wire logic [WORD_W-1:0] i_word,
    output logic                   o_hit,
    output logic                   o_valid,
    output logic                   o_dirty,
    output logic [TAG_W-1:0]       o_tag,
    output logic [31:0]            o_rdata,
    input  wire logic              i_wrEn,
    input  wire logic [WORD_W-1:0] i_wrWord,
    input  wire logic [31:0]       i_wrData,
    input  wire logic              i_setDirty,
    input  wire logic              i_fill
);
    logic [31:0]      r_data [SETS][WORDS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_set] <= 1'b1;
            r_dirty[i_set] <= 1'b0;
        end else if (i_setDirty) begin
            r_dirty[i_set] <= 1'b1;
        end
    end

    // Data and tags survive reset; the cleared valid bits make them unreachable.
    always_ff @(posedge clk) begin
        if (i_wrEn) r_data[i_set][i_wrWord] <= i_wrData;
        if (i_fill) r_tag[i_set] <= i_tag;
    end

    assign o_valid = r_valid[i_set];
    assign o_dirty = r_dirty[i_set];
    assign o_tag   = r_tag[i_set];
    assign o_hit   = r_valid[i_set] && (r_tag[i_set] == i_tag);
    assign o_rdata = r_data[i_set][i_word];

endmodule
`default_nettype wire

// File: rtl/dcache_2way.sv
`default_nettype none
// ============================================================================
// Module      : dcache_2way
// Description : 2-way set-associative write-back/write-allocate data cache.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_2way
    import dcache_2way_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input wire logic     clk,
    input wire logic     rst,
    dcache_2way_if.slave bus
);
    localparam int c_WORD_IW = idxWidth(WORDS);
    localparam int c_WORD_W  = fieldWidth(WORDS);
    localparam int c_SET_IW  = idxWidth(SETS);
    localparam int c_SET_W   = fieldWidth(SETS);
    localparam int c_TAG_W   = tagWidth(ADDR_W, SETS, WORDS);
    localparam int c_SET_LSB = c_OFFSET_W + c_WORD_IW;
    localparam int c_TAG_LSB = c_SET_LSB + c_SET_IW;

    state_t              r_state;
    state_t              w_nextState;
    logic [c_WORD_W-1:0] r_beat;
    logic [SETS-1:0]     r_lru;

    logic [c_WORD_W-1:0] w_reqWord;
    logic [c_SET_W-1:0]  w_reqSet;
    logic [c_TAG_W-1:0]  w_reqTag;
    logic                w_hit;
    logic                w_hitWay;
    logic                w_victim;
    logic                w_lastBeat;

    logic [1:0]          w_wayHit;
    logic [1:0]          w_wayValid;
    logic [1:0]          w_wayDirty;
    logic [c_TAG_W-1:0]  w_wayTag   [2];
    logic [31:0]         w_wayRdata [2];
    logic [1:0]          w_wrEn;
    logic [1:0]          w_setDirty;
    logic [1:0]          w_fill;
    logic [c_WORD_W-1:0] w_rdWord;
    logic [c_WORD_W-1:0] w_wrWord;
    logic [31:0]         w_wrData;

    assign w_reqWord  = c_WORD_W'((bus.req_addr >> c_OFFSET_W) & ADDR_W'(WORDS - 1));
    assign w_reqSet   = c_SET_W'(bus.req_addr >> c_SET_LSB);
    assign w_reqTag   = c_TAG_W'(bus.req_addr >> c_TAG_LSB);
    assign w_hit      = bus.req_valid & (|w_wayHit);
    assign w_hitWay   = w_wayHit[1];
    assign w_victim   = r_lru[w_reqSet];
    assign w_lastBeat = (r_beat == c_WORD_W'(WORDS - 1));

    function automatic logic [ADDR_W-1:0] beatAddr(input logic [c_TAG_W-1:0]  tag,
                                                   input logic [c_SET_W-1:0]  setIdx,
                                                   input logic [c_WORD_W-1:0] beat);
        return (ADDR_W'(tag) << c_TAG_LSB) | (ADDR_W'(setIdx) << c_SET_LSB)
             | ((ADDR_W'(beat) & ADDR_W'(WORDS - 1)) << c_OFFSET_W);
    endfunction

    generate
        for (genvar i = 0; i < 2; i++) begin : g_way
            dcache_way #(
                .SETS   (SETS),
                .WORDS  (WORDS),
                .TAG_W  (c_TAG_W),
                .SET_W  (c_SET_W),
                .WORD_W (c_WORD_W)
            ) u_way (
                .clk        (clk),
                .rst        (rst),
                .i_set      (w_reqSet),
                .i_tag      (w_reqTag),
                .i_word     (w_rdWord),
                .o_hit      (w_wayHit[i]),
                .o_valid    (w_wayValid[i]),
                .o_dirty    (w_wayDirty[i]),
                .o_tag      (w_wayTag[i]),
                .o_rdata    (w_wayRdata[i]),
                .i_wrEn     (w_wrEn[i]),
                .i_wrWord   (w_wrWord),
                .i_wrData   (w_wrData),
                .i_setDirty (w_setDirty[i]),
                .i_fill     (w_fill[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_lru   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE) begin
                r_beat <= '0;
            end else if (bus.mem_ready) begin
                r_beat <= w_lastBeat ? '0 : r_beat + 1'b1;
            end
            if ((r_state == S_IDLE) && w_hit) r_lru[w_reqSet] <= ~w_hitWay;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_rdWord      = w_reqWord;
        w_wrWord      = w_reqWord;
        w_wrData      = '0;
        w_wrEn        = '0;
        w_setDirty    = '0;
        w_fill        = '0;
        bus.rdata     = '0;
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_hit) begin
                        bus.rdata = w_wayRdata[w_hitWay];
                        if (bus.req_we) begin
                            w_wrEn[w_hitWay]     = 1'b1;
                            w_setDirty[w_hitWay] = 1'b1;
                            w_wrData = byteMerge(w_wayRdata[w_hitWay], bus.req_wdata, bus.req_be);
                        end
                    end else begin
                        bus.stall   = 1'b1;
                        w_nextState = (w_wayValid[w_victim] && w_wayDirty[w_victim]) ? S_WB : S_REFILL;
                    end
                end
            end
            S_WB: begin
                // Both ways read the beat word; only the victim's copy is driven out.
                w_rdWord      = r_beat;
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = beatAddr(w_wayTag[w_victim], w_reqSet, r_beat);
                bus.mem_wdata = w_wayRdata[w_victim];
                if (bus.mem_ready && w_lastBeat) w_nextState = S_REFILL;
            end
            S_REFILL: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = beatAddr(w_reqTag, w_reqSet, r_beat);
                if (bus.mem_ready) begin
                    w_wrEn[w_victim] = 1'b1;
                    w_wrWord         = r_beat;
                    w_wrData         = bus.mem_rdata;
                    if (w_lastBeat) begin
                        w_fill[w_victim] = 1'b1;
                        w_nextState      = S_IDLE;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_2way.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_2way
// Description : Directed bench with memory model and beat scoreboard for dcache_2way.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_2way;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_2way_if #(.ADDR_W(32)) bus ();

    dcache_2way #(.SETS(64), .WORDS(4), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t       expQ [$];
    logic [31:0] memArr [logic [31:0]];
    int          nAssert = 0;
    int          nFail   = 0;
    int          waitCycles = 0;
    int          waitCnt    = 0;
    logic        prevPending = 1'b0;
    logic [31:0] prevAddr    = '0;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder and beat scoreboard; runs after the stimulus settles each cycle.
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (prevPending && !rst) begin
            check("memReqHeld", {31'd0, bus.mem_req}, 32'd1);
            check("memAddrHeld", bus.mem_addr, prevAddr);
        end
        if (bus.mem_req && !rst) begin
            if (waitCnt >= waitCycles) begin
                bus.mem_ready = 1'b1;
                waitCnt = 0;
            end else begin
                bus.mem_ready = 1'b0;
                waitCnt++;
            end
        end else begin
            bus.mem_ready = 1'b0;
            waitCnt = 0;
        end
        bus.mem_rdata = memRead(bus.mem_addr);
        prevPending   = bus.mem_req && !bus.mem_ready && !rst;
        prevAddr      = bus.mem_addr;
        if (bus.mem_req && bus.mem_ready) begin
            if (expQ.size() == 0) begin
                check("unexpectedBeat", bus.mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                check("beatWe", {31'd0, bus.mem_we}, {31'd0, e.we});
                check("beatAddr", bus.mem_addr, e.addr);
                if (e.we) check("beatWdata", bus.mem_wdata, e.data);
            end
            if (bus.mem_we) memArr[bus.mem_addr] = bus.mem_wdata;
        end
    end

    task automatic pushRead(input logic [31:0] base);
        beat_t e;
        for (int i = 0; i < 4; i++) begin
            e.we = 1'b0; e.addr = base + 32'(4 * i); e.data = '0;
            expQ.push_back(e);
        end
    endtask

    task automatic pushWrite(input logic [31:0] base, input logic [31:0] d [4]);
        beat_t e;
        for (int i = 0; i < 4; i++) begin
            e.we = 1'b1; e.addr = base + 32'(4 * i); e.data = d[i];
            expQ.push_back(e);
        end
    endtask

    // Starts at a falling edge; counts stalled cycles, then returns one edge later.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output int cycles);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        cycles = 0;
        #1;
        while (bus.stall === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        rd = bus.rdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] expData,
                        input int expStall, input string tag);
        logic [31:0] rd;
        int          cyc;
        access(1'b0, addr, 32'd0, 4'd0, rd, cyc);
        check({tag, "Data"}, rd, expData);
        check({tag, "Stall"}, 32'(cyc), 32'(expStall));
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                         input int expStall, input string tag);
        logic [31:0] rd;
        int          cyc;
        access(1'b1, addr, data, be, rd, cyc);
        check({tag, "Stall"}, 32'(cyc), 32'(expStall));
    endtask

    initial begin
        logic [31:0] wb [4];
        int          cyc;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        memArr[32'h1000] = 32'h0000_00A0;
        memArr[32'h1004] = 32'h0000_00A1;
        memArr[32'h1008] = 32'h0000_00A2;
        memArr[32'h100C] = 32'h0000_00A3;
        memArr[32'h2014] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstStall", {31'd0, bus.stall}, 32'd0);
        check("rstMemReq", {31'd0, bus.mem_req}, 32'd0);
        check("rstRdata", bus.rdata, 32'd0);
        @(negedge clk);

        pushRead(32'h1000);
        load(32'h1004, 32'h0000_00A1, 5, "coldLoad");
        load(32'h1000, 32'h0000_00A0, 0, "hitLoad");

        pushRead(32'h2010);
        load(32'h2014, 32'h1122_3344, 5, "fillStoreLine");
        store(32'h2014, 32'hDEAD_BEEF, 4'b0011, 0, "storeHit");
        load(32'h2014, 32'h1122_BEEF, 0, "mergedLoad");

        store(32'h1000, 32'hCAFE_0000, 4'b1111, 0, "dirtyLine");
        pushRead(32'h5000);
        load(32'h5000, memRead(32'h5000), 5, "fill5000");
        wb = '{32'hCAFE_0000, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        pushWrite(32'h1000, wb);
        pushRead(32'h9000);
        load(32'h9000, memRead(32'h9000), 9, "evictDirty");
        load(32'h5000, memRead(32'h5000), 0, "keep5000");

        waitCycles = 3;
        pushRead(32'h6010);
        load(32'h6010, memRead(32'h6010), 17, "slowRefill");
        waitCycles = 0;

        wb = '{memRead(32'h2010), 32'h1122_BEEF, memRead(32'h2018), memRead(32'h201C)};
        pushWrite(32'h2010, wb);
        pushRead(32'h7010);
        load(32'h7010, memRead(32'h7010), 9, "evictStored");

        // Dirty way1 (0x5000 line) becomes the victim, then reset lands on write beat 2.
        store(32'h5004, 32'h1234_5678, 4'b1111, 0, "dirty5004");
        load(32'h9000, memRead(32'h9000), 0, "touch9000");
        wb = '{memRead(32'h5000), 32'h1234_5678, 32'd0, 32'd0};
        for (int i = 0; i < 2; i++) begin
            beat_t e;
            e.we = 1'b1; e.addr = 32'h5000 + 32'(4 * i); e.data = wb[i];
            expQ.push_back(e);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_D000;
        cyc = 0;
        #1;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 32'h5008) && cyc < 50) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check("reachWbBeat2", 32'(cyc), 32'd3);
        check("wbBeat2We", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rstMidMemReq", {31'd0, bus.mem_req}, 32'd0);
        check("rstMidStall", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        pushRead(32'h1000);
        load(32'h1000, 32'hCAFE_0000, 5, "postRstLoad");

        pushRead(32'h0020);
        load(32'h0020, memRead(32'h0020), 5, "fillA");
        pushRead(32'h0420);
        load(32'h0420, memRead(32'h0420), 5, "fillB");
        load(32'h0420, memRead(32'h0420), 0, "hitB1");
        load(32'h0020, memRead(32'h0020), 0, "hitA1");
        pushRead(32'h0820);
        load(32'h0820, memRead(32'h0820), 5, "missC1");
        load(32'h0020, memRead(32'h0020), 0, "lru1KeepA");
        pushRead(32'h0420);
        load(32'h0420, memRead(32'h0420), 5, "lru1LostB");

        load(32'h0020, memRead(32'h0020), 0, "hitA2");
        load(32'h0420, memRead(32'h0420), 0, "hitB2");
        pushRead(32'h0820);
        load(32'h0820, memRead(32'h0820), 5, "missC2");
        load(32'h0420, memRead(32'h0420), 0, "lru2KeepB");
        pushRead(32'h0020);
        load(32'h0020, memRead(32'h0020), 5, "lru2LostA");

        repeat (2) @(negedge clk);
        check("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_2way.md
Name: dcache_2way

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the memory stage of the 5-stage pipeline and the unified main-memory bus.
- Hits complete combinationally, with zero added latency.
- Misses raise a stall toward the hazard unit while a multi-beat dirty-victim writeback and a block refill run on the memory side.

Parameters:
- SETS, 64, number of sets; power of 2, minimum 2.
- WORDS, 4, 32-bit words per block; power of 2, minimum 1.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  memory-stage access present (load or store).
- req_we  in  1  1 = store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, already lane-aligned.
- req_be  in  4  store byte enables.
- rdata  out  32  load data for the addressed word.
- stall  out  1  freeze the pipeline; the request must be held stable while high.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  32  writeback data.
- mem_ready  in  1  beat accepted / read data valid this cycle.
- mem_rdata  in  32  refill data.

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Address split: offset[1:0] ignored; word index log2(WORDS); set index log2(SETS); tag = remaining upper bits.
- Per set: two ways, each holding valid, dirty, tag, WORDS data words. One LRU bit per set names the victim way.
- Hit test: req_valid & valid[w] & (tag[w]==req tag), for either way.
- Multi-hit cannot occur; the refill only ever writes the victim.
- FSM states: IDLE, WB, REFILL.
- IDLE, hit:
  - stall=0.
  - Load: rdata = hit word combinationally.
  - Store: on the clock edge, apply req_be byte-wise to the hit word and set dirty.
  - Any hit sets LRU to point at the other way.
- IDLE, miss:
  - stall=1 the same cycle.
  - Victim = LRU way.
  - Victim valid & dirty: go to WB, beat counter = 0. Otherwise go to REFILL, beat counter = 0.
- WB:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, set, beat, 2'b00}, mem_wdata = victim word[beat].
  - On mem_ready: beat++. After the beat WORDS-1 is accepted, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, set, beat, 2'b00}.
  - On mem_ready: write mem_rdata into victim word[beat].
  - On the final beat also write tag, valid=1, dirty=0, then go to IDLE.
- Retry after refill: in IDLE the held request hits, so stall drops and a store merges then. A refill therefore costs WORDS beats + 1 cycle.
- stall = 1 whenever state != IDLE, or in IDLE with req_valid & miss.
- mem_req holds high across beats while mem_ready is low. Outputs are stable until accepted.
- req_valid=0 in IDLE: no action, stall=0, rdata don't-care (drive 0).
- Reset (any state, including mid-burst):
  - Next edge clears all valid, dirty and LRU bits, beat counter = 0, state = IDLE.
  - mem_req=0 and stall=0 from that edge.
  - Dirty data is discarded. Data arrays are not cleared.
- No flush port in this revision. Uncached/MMIO access (trigger) is decoded outside this block.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/WB/REFILL).
  - Width helpers for offset, index and tag derived from SETS/WORDS/ADDR_W.
  - Byte-merge function for req_be.
- One natural sub-module, dcache_way: tag/valid/dirty/data storage for one way, with hit compare and word read. It is instantiated twice.
- FSM, LRU array and memory-side muxing stay in dcache_2way.

Test Plan:
- Cold load 0x0000_1004, mem returns 0xA0..0xA3 on consecutive beats (mem_ready every cycle): stall high for 5 cycles; mem_addr beats 0x1000, 0x1004, 0x1008, 0x100C; then rdata=0xA1, stall=0.
- Store 0xDEADBEEF, be=4'b0011, to resident word holding 0x11223344: no stall; subsequent load returns 0x1122BEEF; line dirty.
- Conflict:
  - Sequence: touch 0x1000 (dirtied), then 0x5000, then 0x9000, all in set 0 with SETS=64, WORDS=4.
  - Required: victim is the 0x1000 line; 4 write beats at 0x1000..0x100C carrying the dirty data, then 4 read beats at 0x9000..; 0x5000 stays resident and hits afterwards.
- mem_ready held low 3 cycles per beat during refill: mem_req and mem_addr stable across the wait cycles; total stall = 4×4+1 cycles.
- rst asserted on WB beat 2: mem_req low after the edge; then load 0x1000 misses and refills, with no writeback.
- Alternating hits to both ways of one set, then a miss: LRU evicts the least-recently-hit way, checked for both orders.
